// File: rtl/draw_pkg.sv
// Shared state encoding, default geometry and pixel colours for the draw sequencer.
package draw_pkg;
    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;
    localparam int DEF_X_W    = 10;
    localparam int DEF_Y_W    = 9;

    localparam logic COLOR_BLACK = 1'b0;
    localparam logic COLOR_WHITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_DRAW   = 2'd3
    } state_e;
endpackage

// File: rtl/draw_sequencer_if.sv
// Request inputs, line drawer handshake and framebuffer write port of the draw sequencer.
interface draw_sequencer_if #(
    parameter int X_W = draw_pkg::DEF_X_W,
    parameter int Y_W = draw_pkg::DEF_Y_W
);
    logic           go;
    logic           clear;
    logic [X_W-1:0] x0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y0;
    logic [Y_W-1:0] y1;
    logic           ld_done;
    logic           ld_wr;
    logic [X_W-1:0] ld_x;
    logic [Y_W-1:0] ld_y;
    logic           ld_start;
    logic [X_W-1:0] ld_x0;
    logic [X_W-1:0] ld_x1;
    logic [Y_W-1:0] ld_y0;
    logic [Y_W-1:0] ld_y1;
    logic           fb_wr;
    logic [X_W-1:0] fb_x;
    logic [Y_W-1:0] fb_y;
    logic           fb_color;
    logic           busy;

    modport master (
        output go, clear, x0, x1, y0, y1, ld_done, ld_wr, ld_x, ld_y,
        input  ld_start, ld_x0, ld_x1, ld_y0, ld_y1, fb_wr, fb_x, fb_y, fb_color, busy
    );

    modport slave (
        input  go, clear, x0, x1, y0, y1, ld_done, ld_wr, ld_x, ld_y,
        output ld_start, ld_x0, ld_x1, ld_y0, ld_y1, fb_wr, fb_x, fb_y, fb_color, busy
    );
endinterface

// File: rtl/draw_sequencer_clear_counter.sv
// Raster x/y counter for the clear pass; flags the bottom-right pixel.
module clear_counter
    import draw_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int X_W    = DEF_X_W,
    parameter int Y_W    = DEF_Y_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           en,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           last
);
    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    assign last = (cx == X_LAST) && (cy == Y_LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cx <= '0;
            cy <= '0;
        end else if (en) begin
            if (cx == X_LAST) begin
                cx <= '0;
                cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/draw_sequencer.sv
// Schedules full-screen clears and single line draws onto one framebuffer write port,
// holding at most one pending request of each kind.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int X_W    = DEF_X_W,
    parameter int Y_W    = DEF_Y_W
) (
    input logic             clk,
    input logic             reset,
    draw_sequencer_if.slave bus
);
    // state  | meaning
    // IDLE   | waiting; dispatches a pending clear ahead of a pending draw
    // CLEAR  | writes black to every pixel in raster order
    // LAUNCH | one-cycle start pulse to the line drawer
    // DRAW   | forwards line drawer pixels in white until ld_done
    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] CLEAR  = ST_CLEAR;
    localparam logic [1:0] LAUNCH = ST_LAUNCH;
    localparam logic [1:0] DRAW   = ST_DRAW;

    logic [1:0]     state, state_nxt;
    logic           pend_go, pend_clr;
    logic           req_go, req_clr, disp_go, disp_clr;
    logic [X_W-1:0] cx, x0_q, x1_q, fb_x_c;
    logic [Y_W-1:0] cy, y0_q, y1_q, fb_y_c;
    logic           cnt_last, fb_wr_c, fb_color_c, ld_start_c;

    // A pulse in the same cycle counts as already pending, so IDLE can dispatch it at once.
    assign req_clr  = pend_clr | bus.clear;
    assign req_go   = pend_go | bus.go;
    assign disp_clr = (state == IDLE) && req_clr;
    assign disp_go  = (state == IDLE) && !req_clr && req_go;

    clear_counter #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_clear_counter (
        .clk  (clk),
        .reset(reset),
        .clr  (state != CLEAR),
        .en   (state == CLEAR),
        .cx   (cx),
        .cy   (cy),
        .last (cnt_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_clr)     state_nxt = CLEAR;
                else if (req_go) state_nxt = LAUNCH;
            end
            CLEAR:   if (cnt_last) state_nxt = IDLE;
            LAUNCH:  state_nxt = DRAW;
            DRAW:    if (bus.ld_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pend_go  <= 1'b0;
            pend_clr <= 1'b0;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
        end else begin
            state    <= state_nxt;
            pend_clr <= req_clr & ~disp_clr;
            pend_go  <= req_go & ~disp_go;
            if (bus.go) begin
                x0_q <= bus.x0;
                x1_q <= bus.x1;
                y0_q <= bus.y0;
                y1_q <= bus.y1;
            end
        end
    end

    always_comb begin
        fb_wr_c    = 1'b0;
        fb_x_c     = '0;
        fb_y_c     = '0;
        fb_color_c = COLOR_BLACK;
        ld_start_c = 1'b0;
        case (state)
            CLEAR: begin
                fb_wr_c = 1'b1;
                fb_x_c  = cx;
                fb_y_c  = cy;
            end
            LAUNCH: ld_start_c = 1'b1;
            DRAW: begin
                fb_wr_c    = bus.ld_wr;
                fb_x_c     = bus.ld_x;
                fb_y_c     = bus.ld_y;
                fb_color_c = COLOR_WHITE;
            end
            default: ;
        endcase
    end

    assign bus.fb_wr    = fb_wr_c;
    assign bus.fb_x     = fb_x_c;
    assign bus.fb_y     = fb_y_c;
    assign bus.fb_color = fb_color_c;
    assign bus.ld_start = ld_start_c;
    assign bus.ld_x0    = x0_q;
    assign bus.ld_x1    = x1_q;
    assign bus.ld_y0    = y0_q;
    assign bus.ld_y1    = y1_q;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer on a 4x3 screen: expected framebuffer writes and launches are
// scheduled by cycle from the sequencing rules and scored against what a monitor records.
module tb_draw_sequencer;
    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [2:0]  ctl_hist [4096];
    logic [31:0] exp_wr[$], act_wr[$], exp_ls[$], act_ls[$];

    draw_sequencer_if #(.X_W(3), .Y_W(2)) bus ();

    draw_sequencer #(.WIDTH(W), .HEIGHT(H), .X_W(3), .Y_W(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mk_wr(input int unsigned c, input logic [2:0] x,
                                          input logic [1:0] y, input logic col);
        return {10'd0, c[15:0], x, y, col};
    endfunction

    function automatic logic [31:0] mk_ls(input int unsigned c, input logic [2:0] a0,
                                          input logic [1:0] b0, input logic [2:0] a1,
                                          input logic [1:0] b1);
        return {6'd0, c[15:0], a0, b0, a1, b1};
    endfunction

    function automatic logic [2:0] ctl_at(input int unsigned c);
        return ctl_hist[c[11:0]];
    endfunction

    // Monitor: per-cycle {busy, fb_wr, ld_start} plus every write and launch seen.
    always @(negedge clk) begin
        ctl_hist[cyc[11:0]] = {bus.busy, bus.fb_wr, bus.ld_start};
        if (bus.fb_wr)    act_wr.push_back(mk_wr(cyc, bus.fb_x, bus.fb_y, bus.fb_color));
        if (bus.ld_start) act_ls.push_back(mk_ls(cyc, bus.ld_x0, bus.ld_y0, bus.ld_x1, bus.ld_y1));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.go      = 1'b0;
        bus.clear   = 1'b0;
        bus.ld_done = 1'b0;
        bus.ld_wr   = 1'b0;
        bus.x0      = 3'($urandom_range(0, 7));
        bus.x1      = 3'($urandom_range(0, 7));
        bus.y0      = 2'($urandom_range(0, 3));
        bus.y1      = 2'($urandom_range(0, 3));
        bus.ld_x    = 3'($urandom_range(0, 7));
        bus.ld_y    = 2'($urandom_range(0, 3));
    endtask

    // Line drawer keeps asserting ld_wr with junk; only legal while the sequencer is not drawing.
    task automatic junk_steps(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ld_wr = 1'b1;
            step();
        end
    endtask

    task automatic push_clear(input int unsigned first);
        for (int k = 0; k < W * H; k++)
            exp_wr.push_back(mk_wr(first + k, 3'(k % W), 2'(k / W), 1'b0));
    endtask

    task automatic draw_job(input int npix, input int clr_idx, input bit coinc,
                            output int unsigned done_cyc);
        bit         seen;
        logic [2:0] h;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            h = ctl_at(cyc - 1);
            if (h[0]) seen = 1'b1;
        end
        chk("launch_seen", 32'(seen), 32'd1);
        done_cyc = cyc;
        for (int p = 0; p < npix; p++) begin
            if ($urandom_range(0, 1) == 1) step();
            bus.ld_wr = 1'b1;
            bus.ld_x  = 3'($urandom_range(0, W - 1));
            bus.ld_y  = 2'($urandom_range(0, H - 1));
            exp_wr.push_back(mk_wr(cyc, bus.ld_x, bus.ld_y, 1'b1));
            if (p == clr_idx) bus.clear = 1'b1;
            if (p == npix - 1 && coinc) begin
                bus.ld_done = 1'b1;
                done_cyc    = cyc;
            end
            step();
        end
        if (!coinc) begin
            bus.ld_done = 1'b1;
            done_cyc    = cyc;
            step();
        end
    endtask

    task automatic compare_queues(input string tag);
        chk({tag, ".wr_count"}, 32'(act_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
            chk({tag, ".wr"}, act_wr[i], exp_wr[i]);
        chk({tag, ".launch_count"}, 32'(act_ls.size()), 32'(exp_ls.size()));
        for (int i = 0; i < exp_ls.size() && i < act_ls.size(); i++)
            chk({tag, ".launch"}, act_ls[i], exp_ls[i]);
        act_wr.delete();
        exp_wr.delete();
        act_ls.delete();
        exp_ls.delete();
    endtask

    initial begin
        int unsigned c, d;
        logic [2:0]  h;
        logic [2:0]  a0, a1;
        logic [1:0]  b0, b1;

        reset       = 1'b1;
        bus.go      = 1'b0;
        bus.clear   = 1'b0;
        bus.x0      = '0;
        bus.x1      = '0;
        bus.y0      = '0;
        bus.y1      = '0;
        bus.ld_done = 1'b0;
        bus.ld_wr   = 1'b0;
        bus.ld_x    = '0;
        bus.ld_y    = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_coords", 32'({bus.ld_x0, bus.ld_y0, bus.ld_x1, bus.ld_y1}), 32'd0);
        c = cyc;
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 4; i++) chk("idle_ctl", 32'(ctl_at(c + i)), 32'd0);
        compare_queues("reset");

        // Plain clear pass.
        c = cyc;
        bus.clear = 1'b1;
        push_clear(c + 1);
        junk_steps(14);
        h = ctl_at(c + 12);
        chk("clr_busy_last", 32'(h[2]), 32'd1);
        chk("clr_busy_drop", 32'(ctl_at(c + 13)), 32'd0);
        junk_steps(2);
        compare_queues("clear");

        // Directed draw with the pixel coincident with ld_done.
        c = cyc;
        bus.go = 1'b1;
        bus.x0 = 3'd1; bus.y0 = 2'd0; bus.x1 = 3'd3; bus.y1 = 2'd2;
        exp_ls.push_back(mk_ls(c + 1, 3'd1, 2'd0, 3'd3, 2'd2));
        draw_job(3, -1, 1'b1, d);
        chk("go_idle_cycle", 32'(ctl_at(c)), 32'd0);
        junk_steps(1);
        chk("draw_to_idle", 32'(ctl_at(d + 1)), 32'd0);
        junk_steps(3);
        compare_queues("draw");

        // go and clear together: clear first, then the launch after one idle cycle.
        c = cyc;
        a0 = 3'($urandom_range(0, 7)); b0 = 2'($urandom_range(0, 3));
        a1 = 3'($urandom_range(0, 7)); b1 = 2'($urandom_range(0, 3));
        bus.go = 1'b1; bus.clear = 1'b1;
        bus.x0 = a0; bus.y0 = b0; bus.x1 = a1; bus.y1 = b1;
        push_clear(c + 1);
        exp_ls.push_back(mk_ls(c + 14, a0, b0, a1, b1));
        junk_steps(13);
        draw_job(int'($urandom_range(1, 4)), -1, 1'($urandom_range(0, 1)), d);
        chk("one_idle_between", 32'(ctl_at(c + 13)), 32'd0);
        junk_steps(1);
        chk("go_clr_idle", 32'(ctl_at(d + 1)), 32'd0);
        junk_steps(3);
        compare_queues("go_clr");

        // go pulses during a clear: queued, the later one overwrites the coordinates.
        c = cyc;
        bus.clear = 1'b1;
        push_clear(c + 1);
        junk_steps(5);
        bus.go = 1'b1;
        bus.x0 = 3'd2;
        junk_steps(1);
        chk("go_mid_clear_x0", 32'(bus.ld_x0), 32'd2);
        junk_steps(1);
        a0 = 3'd3;                     b0 = 2'($urandom_range(0, 3));
        a1 = 3'($urandom_range(0, 7)); b1 = 2'($urandom_range(0, 3));
        bus.go = 1'b1;
        bus.x0 = a0; bus.y0 = b0; bus.x1 = a1; bus.y1 = b1;
        exp_ls.push_back(mk_ls(c + 14, a0, b0, a1, b1));
        junk_steps(6);
        draw_job(int'($urandom_range(1, 4)), -1, 1'($urandom_range(0, 1)), d);
        junk_steps(4);
        compare_queues("go_in_clear");

        // Reset in DRAW with queued clear and go; the drawer keeps writing throughout.
        c = cyc;
        a0 = 3'($urandom_range(0, 7)); b0 = 2'($urandom_range(0, 3));
        a1 = 3'($urandom_range(0, 7)); b1 = 2'($urandom_range(0, 3));
        bus.go = 1'b1;
        bus.x0 = a0; bus.y0 = b0; bus.x1 = a1; bus.y1 = b1;
        exp_ls.push_back(mk_ls(c + 1, a0, b0, a1, b1));
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            bus.ld_wr = 1'b1;
            bus.ld_x  = 3'($urandom_range(0, W - 1));
            bus.ld_y  = 2'($urandom_range(0, H - 1));
            exp_wr.push_back(mk_wr(cyc, bus.ld_x, bus.ld_y, 1'b1));
            if (i == 0) bus.clear = 1'b1;
            if (i == 1) bus.go = 1'b1;
            if (i == 2) reset = 1'b1;
            step();
        end
        bus.ld_wr = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_draw_coords", 32'({bus.ld_x0, bus.ld_y0, bus.ld_x1, bus.ld_y1}), 32'd0);
        c = cyc;
        junk_steps(8);
        for (int i = 0; i < 8; i++) chk("post_rst_ctl", 32'(ctl_at(c + i)), 32'd0);
        compare_queues("reset_draw");

        // Random draws with a clear queued mid-draw.
        for (int it = 0; it < 3; it++) begin
            int np;
            np = int'($urandom_range(1, 4));
            c = cyc;
            a0 = 3'($urandom_range(0, 7)); b0 = 2'($urandom_range(0, 3));
            a1 = 3'($urandom_range(0, 7)); b1 = 2'($urandom_range(0, 3));
            bus.go = 1'b1;
            bus.x0 = a0; bus.y0 = b0; bus.x1 = a1; bus.y1 = b1;
            exp_ls.push_back(mk_ls(c + 1, a0, b0, a1, b1));
            draw_job(np, int'($urandom_range(0, np - 1)), 1'($urandom_range(0, 1)), d);
            push_clear(d + 2);
            junk_steps(1);
            chk("queued_clr_gap", 32'(ctl_at(d + 1)), 32'd0);
            junk_steps(14);
            h = ctl_at(d + 13);
            chk("queued_clr_busy", 32'(h[2]), 32'd1);
            chk("queued_clr_end", 32'(ctl_at(d + 14)), 32'd0);
            compare_queues("draw_then_clear");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Top-level scheduler between the sanitized button pulses and the framebuffer write port.
- Sequences two jobs: a full-screen clear pass (internal pixel counter) and one line-draw command (start/done handshake to the line drawer).
- Arbitrates the single framebuffer write port between the clear engine and the line drawer's pixel stream.
- Queues at most one pending request of each kind while busy.

Parameters:
- WIDTH, 640, screen width in pixels.
- HEIGHT, 480, screen height in pixels.
- X_W, 10, x coordinate width; must satisfy 2**X_W >= WIDTH.
- Y_W, 9, y coordinate width; must satisfy 2**Y_W >= HEIGHT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  single-cycle draw request pulse (already sanitized).
- clear  in  1  single-cycle clear request pulse (already sanitized).
- x0, x1  in  X_W  line endpoints x, sampled on go.
- y0, y1  in  Y_W  line endpoints y, sampled on go.
- ld_done  in  1  line drawer finished; one-cycle pulse.
- ld_wr  in  1  line drawer pixel valid.
- ld_x  in  X_W  line drawer pixel x.
- ld_y  in  Y_W  line drawer pixel y.
- ld_start  out  1  one-cycle start pulse to the line drawer.
- ld_x0, ld_x1  out  X_W  latched endpoints x to the line drawer.
- ld_y0, ld_y1  out  Y_W  latched endpoints y to the line drawer.
- fb_wr  out  1  framebuffer write enable.
- fb_x  out  X_W  framebuffer write x.
- fb_y  out  Y_W  framebuffer write y.
- fb_color  out  1  pixel value; 0 = black, 1 = white.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, synchronous and active-high, takes priority over everything:
  - state = IDLE; clear counters cx, cy = 0.
  - pend_go, pend_clr = 0; latched coordinates = 0.
  - All outputs 0.
  - Reset asserted mid-CLEAR or mid-DRAW aborts the job immediately; no further fb_wr from the next cycle.
- Request capture, each edge:
  - A go or clear pulse sets pend_go or pend_clr respectively.
  - A go pulse also loads x0, y0, x1, y1 into the ld_* registers.
  - A go pulse arriving while a go is already pending overwrites the coordinates; it does not create a second job.
  - The pending flag is cleared in the cycle its job is dispatched.
- States (Moore outputs, combinational from state and counters; zero latency):
  - IDLE:
    - If pend_clr or clear, go to CLEAR with cx = cy = 0. Clear has priority over go.
    - Else if pend_go or go, go to LAUNCH.
    - A go that is not dispatched remains pending.
  - CLEAR:
    - fb_wr = 1, fb_x = cx, fb_y = cy, fb_color = 0.
    - Each cycle, cx increments.
    - At cx == WIDTH-1, cx wraps to 0 and cy increments.
    - At (WIDTH-1, HEIGHT-1), that last write occurs and the next state is IDLE.
    - Exactly WIDTH*HEIGHT write cycles, each address written exactly once.
  - LAUNCH:
    - ld_start = 1 for exactly one cycle; fb_wr = 0; next state DRAW.
  - DRAW:
    - fb_wr = ld_wr, fb_x = ld_x, fb_y = ld_y, fb_color = 1.
    - On ld_done, next state IDLE. A pixel coincident with ld_done is still forwarded.
- The line drawer's ld_wr is masked to 0 outside DRAW.
- In non-CLEAR states, fb_x and fb_y are 0 unless in DRAW.
- ld_start is never asserted outside LAUNCH.
- Back-to-back jobs: a pending job is dispatched from IDLE after one IDLE cycle; there is no direct CLEAR-to-LAUNCH path.
- A clear pulse during DRAW does not abort the draw; it is queued.
- Arithmetic:
  - cx and cy are unsigned, compared against WIDTH-1 and HEIGHT-1.
  - No counter value outside the screen is ever driven.

Decomposition:
- Package draw_pkg:
  - state enum {IDLE, CLEAR, LAUNCH, DRAW}.
  - Default WIDTH, HEIGHT, X_W, Y_W constants.
  - COLOR_BLACK, COLOR_WHITE constants.
- One natural sub-module, clear_counter: x/y raster counter with enable, synchronous clear and a last-pixel flag, parameterised by WIDTH and HEIGHT.

Test Plan (WIDTH=4, HEIGHT=3, X_W=3, Y_W=2):
- Reset held 2 cycles, then released with no inputs -> busy=0, fb_wr=0, ld_start=0 continuously.
- clear pulse -> exactly 12 consecutive fb_wr cycles, fb_color=0, addresses (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2); busy drops the cycle after (3,2).
- go with x0=1, y0=0, x1=3, y1=2 -> ld_start a single cycle after one IDLE cycle, ld_* = 1/0/3/2. Model emits 3 pixels with ld_wr; they appear on fb with fb_color=1. ld_done -> IDLE.
- go and clear in the same cycle -> clear runs first (12 writes), then the draw launches with the coordinates sampled at the go pulse.
- go pulse at clear cycle 5 with x0=2 -> no ld_start during CLEAR; launch follows clear with ld_x0=2. A second go at cycle 7 with x0=3 -> only one launch, ld_x0=3.
- Reset asserted in DRAW while the model still drives ld_wr -> fb_wr=0 from the next cycle; pending flags are cleared; no launch after release.
